// File: rtl/vec_halving_add_seq.sv
// vec_halving_add_seq
// Operand sequencer and result collector for an external 8-bit halving adder.
// One vector pair is accepted per handshake, lanes are issued to the adder one
// per cycle, and the truncated sums are gathered into a result vector that is
// presented on a valid/ready output stream.
module vec_halving_add_seq #(
  parameter  int LANES = 8,
  localparam int LEN_W = $clog2(LANES + 1),
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_a,
  input  logic [8*LANES-1:0]   in_b,
  input  logic                 in_c0,
  input  logic [LEN_W-1:0]     in_len,
  output logic                 add_en,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_c0,
  input  logic [7:0]           add_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_vec,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic             c0_q;
  logic [7:0]       a_q   [LANES];
  logic [7:0]       b_q   [LANES];
  logic [7:0]       res_q [LANES];

  logic             accept;
  logic             last_lane;
  logic [LEN_W-1:0] len_clamped;

  // Requests above LANES are treated as a full vector.
  assign len_clamped = (in_len > LEN_W'(LANES)) ? LEN_W'(LANES) : in_len;
  assign accept      = in_valid && (state_q == IDLE);
  assign last_lane   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and state-derived outputs (no path from in_valid/out_ready
  // to in_ready/out_valid).
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_en    = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_c0    = 1'b0;
    out_vec   = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (len_clamped == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        busy   = 1'b1;
        add_en = 1'b1;
        add_a  = a_q[idx_q];
        add_b  = b_q[idx_q];
        add_c0 = c0_q;
        if (last_lane) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        for (int i = 0; i < LANES; i++) out_vec[8*i +: 8] = res_q[i];
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on acceptance, and lane-by-lane result collection.
  // The result register is cleared on acceptance so lanes at or above len read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      len_q <= '0;
      c0_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q <= '0;
            len_q <= len_clamped;
            c0_q  <= in_c0;
            for (int i = 0; i < LANES; i++) begin
              a_q[i]   <= in_a[8*i +: 8];
              b_q[i]   <= in_b[8*i +: 8];
              res_q[i] <= '0;
            end
          end
        end
        ISSUE: begin
          res_q[idx_q] <= add_sum;
          idx_q        <= last_lane ? '0 : idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_halving_add_seq.sv
// Directed testbench for vec_halving_add_seq with a behavioural halving adder.
module tb_vec_halving_add_seq;

  localparam int LANES = 8;
  localparam int LEN_W = $clog2(LANES + 1);

  typedef int lanes_t [LANES];

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [8*LANES-1:0] in_a = '0;
  logic [8*LANES-1:0] in_b = '0;
  logic               in_c0 = 1'b0;
  logic [LEN_W-1:0]   in_len = '0;
  logic               add_en;
  logic [7:0]         add_a;
  logic [7:0]         add_b;
  logic               add_c0;
  logic [7:0]         add_sum;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [8*LANES-1:0] out_vec;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // External adder: 9-bit sign-extended sum, bits [8:1] kept.
  logic [8:0] sum9;
  assign sum9    = {add_a[7], add_a} + {add_b[7], add_b} + {8'd0, add_c0};
  assign add_sum = sum9[8:1];

  vec_halving_add_seq #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c0     (in_c0),
    .in_len    (in_len),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c0    (add_c0),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8*LANES-1:0] pack(input lanes_t v);
    logic [8*LANES-1:0] r;
    logic [31:0]        w;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      w = v[i];
      r[8*i +: 8] = w[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector pair, complete the handshake, then wait for out_valid.
  // n_edges counts edges after the handshake edge until out_valid is seen.
  task automatic run(input logic [8*LANES-1:0] a, input logic [8*LANES-1:0] b,
                     input logic c0, input logic [LEN_W-1:0] len,
                     output int n_edges, output int n_en);
    int guard;
    in_a = a; in_b = b; in_c0 = c0; in_len = len; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    n_edges = 0;
    n_en    = 0;
    while (!out_valid && n_edges < 40) begin
      if (add_en) n_en++;
      tick();
      n_edges++;
    end
    if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  lanes_t va, vb, ve;
  logic [8*LANES-1:0] basic_a, basic_b, basic_exp, held;
  int n_edges, n_en;
  int acc_at [$];

  initial begin
    va = '{100, -1, 127, -128, 5, 0, -3, 64};
    vb = '{27, 0, 127, -128, 6, 0, -4, 64};
    ve = '{64, 0, 127, -128, 6, 0, -3, 64};
    basic_a   = pack(va);
    basic_b   = pack(vb);
    basic_exp = pack(ve);

    // Reset state.
    #12;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_add_en",    {63'd0, add_en},    64'd0);
    check("rst_out_vec",   out_vec,            64'd0);
    rst_n = 1'b1;
    tick();

    // Basic: len=8, c0=1.
    run(basic_a, basic_b, 1'b1, 4'd8, n_edges, n_en);
    check("basic_vec",     out_vec,       basic_exp);
    check("basic_latency", 64'(n_edges),  64'd8);
    check("basic_add_en",  64'(n_en),     64'd8);
    check("basic_busy",    {63'd0, busy}, 64'd1);
    pop();
    check("basic_idle",    {63'd0, in_ready}, 64'd1);

    // Floor with c0=0; lanes 4..7 carry garbage beyond len=4.
    va = '{-1, 3, -128, 127, 9, 9, 9, 9};
    vb = '{0, 0, -128, 127, 9, 9, 9, 9};
    ve = '{-1, 1, -128, 127, 0, 0, 0, 0};
    run(pack(va), pack(vb), 1'b0, 4'd4, n_edges, n_en);
    check("floor_vec", out_vec, pack(ve));
    pop();

    // Partial length 3.
    ve = '{64, 0, 127, 0, 0, 0, 0, 0};
    run(basic_a, basic_b, 1'b1, 4'd3, n_edges, n_en);
    check("len3_vec",     out_vec,      pack(ve));
    check("len3_latency", 64'(n_edges), 64'd3);
    check("len3_add_en",  64'(n_en),    64'd3);
    pop();

    // Zero length.
    run(basic_a, basic_b, 1'b1, 4'd0, n_edges, n_en);
    check("len0_vec",     out_vec,      64'd0);
    check("len0_latency", 64'(n_edges), 64'd0);
    check("len0_add_en",  64'(n_en),    64'd0);
    pop();

    // Clamp: in_len=15 behaves as 8.
    run(basic_a, basic_b, 1'b1, 4'd15, n_edges, n_en);
    check("clamp_vec",     out_vec,      basic_exp);
    check("clamp_latency", 64'(n_edges), 64'd8);

    // Backpressure: out_ready held low for 5 cycles in DONE.
    held = out_vec;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_vec",       out_vec,              held);
      check("bp_in_ready",  {63'd0, in_ready},    64'd0);
      check("bp_out_valid", {63'd0, out_valid},   64'd1);
    end
    pop();
    check("bp_release_idle",  {63'd0, in_ready},  64'd1);
    check("bp_release_valid", {63'd0, out_valid}, 64'd0);

    // Back-to-back acceptances at len+2 spacing with out_ready held high.
    in_a = basic_a; in_b = basic_b; in_c0 = 1'b1; in_len = 4'd2;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (in_ready) acc_at.push_back(k);
      tick();
    end
    in_valid = 1'b0;
    check("b2b_count", 64'(acc_at.size()), 64'd4);
    if (acc_at.size() >= 3) begin
      check("b2b_gap0", 64'(acc_at[1] - acc_at[0]), 64'd4);
      check("b2b_gap1", 64'(acc_at[2] - acc_at[1]), 64'd4);
    end
    for (int k = 0; k < 6; k++) tick();
    out_ready = 1'b0;
    check("b2b_drained", {63'd0, in_ready}, 64'd1);

    // Reset during lane 4 of ISSUE.
    in_a = basic_a; in_b = basic_b; in_c0 = 1'b1; in_len = 4'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst_add_a", {56'd0, add_a}, 64'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("mid_rst_busy",      {63'd0, busy},      64'd0);
    check("mid_rst_add_en",    {63'd0, add_en},    64'd0);
    check("mid_rst_add_ab",    {47'd0, add_a, add_b, add_c0}, 64'd0);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_vec",   out_vec,            64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh vector after reset; partial length exposes any residue.
    va = '{10, -20, 0, 0, 0, 0, 0, 0};
    vb = '{11, -21, 0, 0, 0, 0, 0, 0};
    ve = '{10, -21, 0, 0, 0, 0, 0, 0};
    run(pack(va), pack(vb), 1'b0, 4'd2, n_edges, n_en);
    check("post_rst_vec",     out_vec,      pack(ve));
    check("post_rst_latency", 64'(n_edges), 64'd2);
    pop();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
